// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold flags and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data instead of the registered read.
module sync_fifo_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wen,
  input  logic [DSIZE-1:0]   wdata,
  input  logic               ren,
  output logic [DSIZE-1:0]   rdata,
  output logic               rvalid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ASIZE:0]     count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF_L = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_L = (ASIZE+1)'(AE_LEVEL);

  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
    end
  endgenerate

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wr_ptr;
  logic [ASIZE:0]   rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // The extra pointer MSB separates full from empty so all DEPTH entries are usable.
  assign full         = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                        (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  assign wr_acc = wen & ~full;
  assign rd_acc = ren & ~empty;

  always_ff @(posedge clk) begin
    if (resetn && wr_acc) begin
      mem[wr_ptr[ASIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event outranks clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wen & full)  | (overflow  & ~clr_err);
      underflow <= (ren & empty) | (underflow & ~clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = mem[rd_ptr[ASIZE-1:0]];
  assign rvalid = ~empty;
`else
  logic [DSIZE-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[rd_ptr[ASIZE-1:0]];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags
// Read data is checked by a monitor against a queue of expected words.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       ren = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       full_seen;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .resetn(resetn), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied just after a rising edge and consumed at the next one.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wen = w; wdata = d; ren = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
    if (resetn && rvalid && ren) begin
`else
    if (rvalid) begin
`endif
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected: got %0h expected none", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
    if (resetn && full) full_seen = 1'b1;
  end

  initial begin
    full_seen = 1'b0;
    @(posedge clk); #1;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    resetn = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_rvalid", rvalid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", rdata, 0);
`endif

    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("fill_count", count, i);
      chk("fill_almost_full", almost_full, (i >= 12) ? 1 : 0);
      chk("fill_almost_empty", almost_empty, (i <= 2) ? 1 : 0);
    end
    chk("fill_full", full, 1);
    cyc(1, 8'hFF, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);

    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      cyc(0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_rvalid", rvalid, 1);
`endif
    end
    chk("drain_empty", empty, 1);
    cyc(0, 8'h00, 1, 0);
    chk("udf_flag", underflow, 1);
    chk("udf_rvalid", rvalid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_rdata_hold", rdata, 8'h10);
`endif
    cyc(0, 8'h00, 0, 1);
    chk("clr_overflow", overflow, 0);
    chk("clr_underflow", underflow, 0);

    full_seen = 1'b0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int j = 0; j < 10; j++) cyc(1, 8'(8'h20 + rep * 16 + j), 0, 0);
      chk("wrap_count10", count, 10);
      for (int j = 0; j < 10; j++) begin
        exp_q.push_back(8'(8'h20 + rep * 16 + j));
        cyc(0, 8'h00, 1, 0);
      end
      chk("wrap_count0", count, 0);
    end
    cyc(0, 8'h00, 0, 0);
    chk("wrap_full_never", full_seen, 0);

    cyc(1, 8'h55, 1, 0);
    chk("sim_empty_count", count, 1);
    chk("sim_empty_underflow", underflow, 1);
    for (int j = 0; j < 4; j++) cyc(1, 8'(8'h60 + j), 0, 0);
    chk("sim_mid_pre", count, 5);
    exp_q.push_back(8'h55);
    cyc(1, 8'h64, 1, 0);
    chk("sim_mid_count", count, 5);
    for (int j = 5; j < 16; j++) cyc(1, 8'(8'h60 + j), 0, 0);
    chk("sim_full_pre", count, 16);
    exp_q.push_back(8'h60);
    cyc(1, 8'hEE, 1, 0);
    chk("sim_full_count", count, 15);
    chk("sim_full_overflow", overflow, 1);
    cyc(0, 8'h00, 0, 1);
    chk("clr2_overflow", overflow, 0);
    chk("clr2_underflow", underflow, 0);

    for (int j = 1; j <= 8; j++) begin
      exp_q.push_back(8'(8'h60 + j));
      cyc(0, 8'h00, 1, 0);
    end
    chk("pre_rst_count", count, 7);
    resetn = 1'b0;
    cyc(0, 8'h00, 1, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_rvalid", rvalid, 0);
    resetn = 1'b1;
    cyc(0, 8'h00, 0, 0);

    cyc(1, 8'hA5, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_rdata", rdata, 8'hA5);
    chk("fwft_rvalid", rvalid, 1);
`endif
    exp_q.push_back(8'hA5);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("final_empty", empty, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO for the UART TX/RX data paths and other byte-stream buffering.
- Adds the following over the previous-generation FIFO:
  - full-depth occupancy using ASIZE+1-bit pointers
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - registered read data with a valid strobe
- Sits between a producer (e.g. UART RX shift logic) and a consumer (e.g. bus interface).

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries, all usable.
- AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- wen  in  1  write request.
- wdata  in  DSIZE  write data.
- ren  in  1  read request.
- rdata  out  DSIZE  read data.
- rvalid  out  1  rdata holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ASIZE+1  current occupancy 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (resetn low at a clk edge):
  - wr_ptr = rd_ptr = 0, count = 0, rdata = 0, rvalid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data at that edge; the in-flight rvalid is cleared.
- Pointers:
  - ASIZE+1 bits; memory is indexed by ptr[ASIZE-1:0].
  - full = (MSBs differ and low bits equal); empty = (pointers equal).
  - Pointers wrap naturally modulo 2**(ASIZE+1).
- Accept rules, evaluated on the current-cycle flags:
  - wr_acc = wen & ~full
  - rd_acc = ren & ~empty
  - Acceptance is independent of the other port: no write-through when empty, no write bypass when full.
- Write: on wr_acc, mem[wr_ptr] <= wdata and wr_ptr += 1.
- Read, 1-cycle latency:
  - On rd_acc, rdata <= mem[rd_ptr], rd_ptr += 1, rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds its last value (never zeroed).
- count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Registered; equals wr_ptr - rd_ptr, width ASIZE+1.
- Flags are registered/derived from registered pointers and count; they update the cycle after the accepting edge.
- Simultaneous wen & ren:
  - When full: read accepted, write rejected, overflow set, count becomes DEPTH-1.
  - When empty: write accepted, read rejected, underflow set, count becomes 1.
  - Otherwise both accepted, count unchanged.
- Error flags:
  - overflow <= 1 when wen & full; underflow <= 1 when ren & empty.
  - clr_err clears both at the next edge.
  - A new error event in the same cycle as clr_err wins (flag stays 1).
- Illegal parameter values (AF_LEVEL outside 1..DEPTH, AE_LEVEL outside 0..DEPTH-1) are caught by an elaboration-time check in simulation.

Optional Feature:
- SYNC_FIFO_FWFT_EN defined (first-word-fall-through):
  - rdata continuously presents mem[rd_ptr] (head word).
  - rvalid = ~empty.
  - ren acts as a pop/acknowledge: on rd_acc the pointer advances and rdata shows the next word in the following cycle.
  - Data from a write into an empty FIFO appears on rdata one cycle after the write edge.
  - All flags, count and error rules are unchanged.
- Undefined: standard 1-cycle registered read as described above.

Test Plan:
- Reset then idle (defaults DSIZE=8, ASIZE=4) -> empty=1, almost_empty=1, count=0, full=0, rvalid=0, rdata=0.
- Write 16 words 0x01..0x10 with no reads -> count=16, full=1, almost_full asserted from count=12.
  - 17th write of 0xFF -> rejected, overflow=1, count stays 16.
- Read 16 words -> rdata 0x01..0x10 in order, each with rvalid one cycle after ren, empty=1 after the last.
  - Extra ren -> underflow=1, rvalid=0, rdata stays 0x10.
- Wrap-around: write 10, read 10, repeated 3 times (pointers cross 16 and 32) -> data order preserved, count=0, full never set.
- Simultaneous wen & ren:
  - at count=16 -> count=15, overflow=1
  - at count=0 -> count=1, underflow=1
  - at count=5 -> count stays 5
  - clr_err pulse -> both flags cleared.
- Reset asserted with count=7 and ren high -> next cycle count=0, empty=1, rvalid=0.
  - With SYNC_FIFO_FWFT_EN: write 0xA5 to empty FIFO -> rdata=0xA5, rvalid=1 one cycle later without ren.
